// File: rtl/arb_burst_ctrl_if.sv
// arb_burst_ctrl_if: request/grant bundle between requesters and arb_burst_ctrl.
// The arbiter connects through the slave modport; the requester side uses master.
interface arb_burst_ctrl_if #(
    parameter int NPORTS = 3
);
    logic [NPORTS-1:0]   req;
    logic [NPORTS-1:0]   en;
    logic [4*NPORTS-1:0] burst_len;
    logic                beat;
    logic [NPORTS-1:0]   grant;
    logic [2:0]          owner;
    logic                busy;
    logic                timeout_err;

    modport master (
        output req, en, burst_len, beat,
        input  grant, owner, busy, timeout_err
    );

    modport slave (
        input  req, en, burst_len, beat,
        output grant, owner, busy, timeout_err
    );
endinterface

// File: rtl/arb_burst_ctrl.sv
// arb_burst_ctrl: round-robin burst arbiter with registered one-hot grant.
// IDLE arbitrates, BURST holds the owner until its beats are done or it
// releases, GAP inserts one dead cycle before the next arbitration.
// Optional watchdog: define ARB_TIMEOUT_EN to revoke a grant after TIMEOUT
// consecutive beat-less cycles (timeout_err pulses in the following GAP).
module arb_burst_ctrl #(
    parameter int NPORTS    = 3,
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    arb_burst_ctrl_if.slave bus
);

    if (NPORTS < 2 || NPORTS > 8 || MAX_BURST < 1 || MAX_BURST > 15 || TIMEOUT < 1) begin : g_bad_param
        $error("arb_burst_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [NPORTS-1:0] r_grant, w_grant_nxt;
    logic [2:0]        r_owner, w_owner_nxt;
    logic [2:0]        r_ptr,   w_ptr_nxt;
    logic [3:0]        r_len,   w_len_nxt;
    logic [3:0]        r_cnt,   w_cnt_nxt;

    logic [7:0]        w_elig8;
    logic              w_owner_ok;
    logic              w_found;
    logic [2:0]        w_winner;
    logic [3:0]        w_sum;
    logic [2:0]        w_cand;
    logic [3:0]        w_raw_len;
    logic [3:0]        w_clamp_len;
    logic              w_tmo;

    // Eligibility padded to 8 bits so a 3-bit index always fits.
    assign w_elig8    = 8'(bus.req & bus.en);
    assign w_owner_ok = w_elig8[r_owner];

    // Round-robin search: first eligible port at or after r_ptr, with wrap.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        w_cand   = '0;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            w_sum  = {1'b0, r_ptr} + 4'(k);
            w_cand = (w_sum >= 4'(NPORTS)) ? 3'(w_sum - 4'(NPORTS)) : 3'(w_sum);
            if (!w_found && w_elig8[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // Winner's requested length, clamped into 1..MAX_BURST.
    always_comb begin
        w_raw_len = '0;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            if (w_winner == 3'(k)) begin
                w_raw_len = bus.burst_len[4*k +: 4];
            end
        end
        if (w_raw_len == 4'd0) begin
            w_clamp_len = 4'd1;
        end else if (w_raw_len > 4'(MAX_BURST)) begin
            w_clamp_len = 4'(MAX_BURST);
        end else begin
            w_clamp_len = w_raw_len;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);

    logic [IW-1:0] r_idle;
    logic          r_terr;

    assign w_tmo = (r_state == BURST) && !bus.beat && (r_idle == IW'(TIMEOUT - 1));

    // Watchdog: count consecutive beat-less BURST cycles; flag the revoke.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle <= '0;
            r_terr <= 1'b0;
        end else begin
            r_terr <= w_tmo;
            if (r_state != BURST || bus.beat) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + 1'b1;
            end
        end
    end

    assign bus.timeout_err = r_terr;
`else
    assign w_tmo           = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // Next-state and next-register logic; defaults hold current values.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = BURST;
                    w_grant_nxt = NPORTS'(1) << w_winner;
                    w_owner_nxt = w_winner;
                    w_len_nxt   = w_clamp_len;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = (w_winner == 3'(NPORTS - 1)) ? 3'd0 : w_winner + 3'd1;
                end
            end
            BURST: begin
                // cnt < len always holds here, so the increment cannot pass len.
                if (bus.beat) begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
                if ((bus.beat && (r_cnt + 4'd1 == r_len)) || !w_owner_ok || w_tmo) begin
                    w_state_nxt = GAP;
                    w_grant_nxt = '0;
                end
            end
            GAP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any burst without a GAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_len   <= w_len_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign bus.grant = r_grant;
    assign bus.owner = r_owner;
    assign bus.busy  = |r_grant;

endmodule

// File: tb/tb_arb_burst_ctrl.sv
// tb_arb_burst_ctrl: directed scenarios plus randomized traffic for
// arb_burst_ctrl, checked against a transaction-level reference model.
module tb_arb_burst_ctrl;

    localparam int N   = 3;
    localparam int MB  = 8;
    localparam int TO  = 16;
    localparam int BLW = 4 * N;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    arb_burst_ctrl_if #(.NPORTS(N)) bus ();

    arb_burst_ctrl #(
        .NPORTS    (N),
        .MAX_BURST (MB),
        .TIMEOUT   (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the bus, how many beats remain, rotation start.
    int m_owner;
    int m_left;
    int m_ptr;
    int m_idle;
    bit m_gap;
    bit m_terr;

    function automatic int clamp_len(input logic [3:0] v);
        if (v == 4'd0) return 1;
        if (int'(v) > MB) return MB;
        return int'(v);
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_left  = 0;
        m_ptr   = 0;
        m_idle  = 0;
        m_gap   = 1'b0;
        m_terr  = 1'b0;
    endfunction

    function automatic void model_step(input logic [N-1:0] rq, input logic [N-1:0] en,
                                       input logic [BLW-1:0] bl, input logic bt);
        bit rel;
        m_terr = 1'b0;
        if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_ptr + k) % N;
                if (m_owner < 0 && rq[p] && en[p]) begin
                    m_owner = p;
                    m_left  = clamp_len(bl[4*p +: 4]);
                    m_ptr   = (p + 1) % N;
                    m_idle  = 0;
                end
            end
        end else begin
            rel = 1'b0;
            if (bt) begin
                m_left = m_left - 1;
                m_idle = 0;
                if (m_left == 0) rel = 1'b1;
            end else begin
                m_idle = m_idle + 1;
`ifdef ARB_TIMEOUT_EN
                if (m_idle == TO) begin
                    rel    = 1'b1;
                    m_terr = 1'b1;
                end
`endif
            end
            if (!(rq[m_owner] && en[m_owner])) rel = 1'b1;
            if (rel) begin
                m_owner = -1;
                m_gap   = 1'b1;
            end
        end
    endfunction

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] g;
        g = '0;
        for (int k = 0; k < N; k++) begin
            if (m_owner == k) g[k] = 1'b1;
        end
        return g;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] g);
        for (int k = 0; k < N; k++) begin
            if (g[k]) return k;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(bus.req, bus.en, bus.burst_len, bus.beat);
        #1;
    endtask

    task automatic apply_reset();
        bus.req       = '0;
        bus.en        = '0;
        bus.burst_len = '0;
        bus.beat      = 1'b0;
        rst_n         = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b1;
        model_reset();
        bus.req       = '1;
        bus.en        = '1;
        bus.burst_len = {4'd4, 4'd4, 4'd4};
        bus.beat      = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (bus.grant !== '0) begin
            bad++; $display("FAIL reset_grant got=%b want=%b", bus.grant, 3'b000);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy got=%b want=0", bus.busy);
        end
        total++;
        if (bus.owner !== 3'd0) begin
            bad++; $display("FAIL reset_owner got=%0d want=0", bus.owner);
        end
        total++;
        if (bus.timeout_err !== 1'b0) begin
            bad++; $display("FAIL reset_terr got=%b want=0", bus.timeout_err);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.grant !== '0) begin
            bad++; $display("FAIL reset_held_grant got=%b want=%b", bus.grant, 3'b000);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] prev;
        int           run_hi;
        int           run_lo;
        int           order[$];
        apply_reset();
        bus.req       = '1;
        bus.en        = '1;
        bus.burst_len = {4'd2, 4'd2, 4'd2};
        bus.beat      = 1'b1;
        prev   = '0;
        run_hi = 0;
        run_lo = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            total++;
            if (bus.grant !== exp_grant()) begin
                bad++; $display("FAIL rr_grant cyc=%0d got=%b want=%b", c, bus.grant, exp_grant());
            end
            if (bus.grant != '0) begin
                if (prev == '0) begin
                    order.push_back(onehot_idx(bus.grant));
                    if (order.size() > 1) begin
                        total++;
                        if (run_lo != 2) begin
                            bad++; $display("FAIL rr_zero_gap got=%0d want=2", run_lo);
                        end
                    end
                end
                run_hi++;
                run_lo = 0;
            end else begin
                if (prev != '0) begin
                    total++;
                    if (run_hi != 2) begin
                        bad++; $display("FAIL rr_hold got=%0d want=2", run_hi);
                    end
                end
                run_hi = 0;
                run_lo++;
            end
            prev = bus.grant;
        end
        total++;
        if (order.size() < 4 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 0) begin
            bad++; $display("FAIL rr_order got=%p want=0,1,2,0", order);
        end
    endtask

    task automatic test_clamp();
        int  run;
        bit  started;
        bit  done;
        logic [3:0] lens[2];
        int  want[2];
        lens[0] = 4'd0;  want[0] = 1;
        lens[1] = 4'd15; want[1] = MB;
        for (int t = 0; t < 2; t++) begin
            apply_reset();
            bus.req       = 3'b010;
            bus.en        = 3'b010;
            bus.burst_len = '0;
            bus.burst_len[7:4] = lens[t];
            bus.beat      = 1'b1;
            run     = 0;
            started = 1'b0;
            done    = 1'b0;
            for (int c = 0; c < 24 && !done; c++) begin
                tick();
                total++;
                if (bus.grant !== exp_grant()) begin
                    bad++; $display("FAIL clamp_grant len=%0d cyc=%0d got=%b want=%b", lens[t], c, bus.grant, exp_grant());
                end
                if (bus.grant == 3'b010) begin
                    run++;
                    started = 1'b1;
                end else if (started) begin
                    done = 1'b1;
                end
            end
            total++;
            if (!done || run != want[t]) begin
                bad++; $display("FAIL clamp_beats len=%0d got=%0d want=%0d", lens[t], run, want[t]);
            end
        end
    endtask

    task automatic test_early_release();
        logic [N-1:0] want[5];
        want[0] = 3'b001; want[1] = 3'b001; want[2] = 3'b000; want[3] = 3'b000; want[4] = 3'b010;
        apply_reset();
        bus.req       = 3'b011;
        bus.en        = 3'b011;
        bus.burst_len = {4'd0, 4'd2, 4'd4};
        bus.beat      = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) bus.req = 3'b010;
            tick();
            total++;
            if (bus.grant !== want[c]) begin
                bad++; $display("FAIL early_release cyc=%0d got=%b want=%b", c, bus.grant, want[c]);
            end
        end
    endtask

    task automatic test_mask();
        bit first_seen;
        apply_reset();
        bus.req       = 3'b001;
        bus.en        = 3'b001;
        bus.burst_len = {4'd1, 4'd1, 4'd1};
        bus.beat      = 1'b1;
        tick();
        bus.req = '0;
        tick();
        tick();
        total++;
        if (bus.grant !== 3'b000) begin
            bad++; $display("FAIL mask_idle got=%b want=%b", bus.grant, 3'b000);
        end
        bus.req       = 3'b111;
        bus.en        = 3'b101;
        bus.burst_len = {4'd3, 4'd3, 4'd3};
        first_seen    = 1'b0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (!first_seen && bus.grant != '0) begin
                first_seen = 1'b1;
                total++;
                if (bus.grant !== 3'b100 || c != 0) begin
                    bad++; $display("FAIL mask_first cyc=%0d got=%b want=%b at cyc 0", c, bus.grant, 3'b100);
                end
            end
            total++;
            if (bus.grant[1] !== 1'b0 || bus.grant !== exp_grant()) begin
                bad++; $display("FAIL mask_grant cyc=%0d got=%b want=%b", c, bus.grant, exp_grant());
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.req       = 3'b111;
        bus.en        = 3'b111;
        bus.burst_len = {4'd4, 4'd4, 4'd4};
        bus.beat      = 1'b1;
        tick();
        tick();
        total++;
        if (bus.grant !== 3'b001) begin
            bad++; $display("FAIL midrst_pre got=%b want=%b", bus.grant, 3'b001);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (bus.grant !== 3'b000 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL midrst_abort grant=%b busy=%b want=000/0", bus.grant, bus.busy);
        end
        @(posedge clk);
        #1;
        bus.req = 3'b110;
        rst_n   = 1'b1;
        tick();
        total++;
        if (bus.grant !== 3'b010 || bus.owner !== 3'd1) begin
            bad++; $display("FAIL midrst_restart grant=%b owner=%0d want=010/1", bus.grant, bus.owner);
        end
    endtask

    task automatic test_hold();
        int run;
        int pulses;
        bit dropped;
        int want_run;
        int want_pulses;
`ifdef ARB_TIMEOUT_EN
        want_run    = TO;
        want_pulses = 1;
`else
        want_run    = 41;
        want_pulses = 0;
`endif
        apply_reset();
        bus.req       = 3'b001;
        bus.en        = 3'b001;
        bus.burst_len = {4'd5, 4'd5, 4'd5};
        bus.beat      = 1'b0;
        run     = 0;
        pulses  = 0;
        dropped = 1'b0;
        for (int c = 0; c < 41; c++) begin
            tick();
            total++;
            if (bus.grant !== exp_grant() || bus.timeout_err !== m_terr) begin
                bad++; $display("FAIL hold_cyc cyc=%0d grant=%b terr=%b want=%b/%b", c, bus.grant, bus.timeout_err, exp_grant(), m_terr);
            end
            if (bus.grant == 3'b001 && !dropped) run++;
            else dropped = 1'b1;
            if (bus.timeout_err === 1'b1) pulses++;
        end
        total++;
        if (run != want_run || pulses != want_pulses) begin
            bad++; $display("FAIL hold_len run=%0d pulses=%0d want=%0d/%0d", run, pulses, want_run, want_pulses);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 9) < 3) bus.req = N'($urandom);
            bus.en        = ($urandom_range(0, 3) != 0) ? '1 : N'($urandom);
            bus.burst_len = BLW'($urandom);
            bus.beat      = ($urandom_range(0, 3) != 0);
            tick();
            total++;
            if (bus.grant !== exp_grant() || bus.busy !== (m_owner >= 0) || bus.timeout_err !== m_terr) begin
                bad++; $display("FAIL rand cyc=%0d grant=%b busy=%b terr=%b want=%b/%b/%b",
                                c, bus.grant, bus.busy, bus.timeout_err, exp_grant(), (m_owner >= 0), m_terr);
            end
            if (m_owner >= 0) begin
                total++;
                if (bus.owner !== 3'(m_owner)) begin
                    bad++; $display("FAIL rand_owner cyc=%0d got=%0d want=%0d", c, bus.owner, m_owner);
                end
            end
        end
    endtask

    initial begin
        bus.req       = '0;
        bus.en        = '0;
        bus.burst_len = '0;
        bus.beat      = 1'b0;
        model_reset();
        #2;
        test_reset();
        test_round_robin();
        test_clamp();
        test_early_release();
        test_mask();
        test_reset_mid();
        test_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

endmodule
